hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl_pkg.sv | 29 ++
 rtl/hazard_stall_ctrl_if.sv | 31 +++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the IF/ID hazard controller: FSM states, the IF/ID NOP word
// and the bundled control-output type.
package hazard_stall_ctrl_pkg;

   localparam logic [1:0] HZ_RUN   = 2'd0;
   localparam logic [1:0] HZ_DWAIT = 2'd1;
   localparam logic [1:0] HZ_IWAIT = 2'd2;

   // add x0,x0,x0 -- loaded into IF/ID on a flush
   localparam logic [31:0] NOP = 32'h0000_0033;

   typedef struct packed {
      logic pc_write;
      logic ifid_stall;
      logic ifid_flush;
      logic idex_bubble;
      logic freeze;
      logic imem_abort;
   } hz_ctrl_t;

   function automatic hz_ctrl_t ctrl_reset();
      hz_ctrl_t c;
      c = '0;
      c.ifid_flush  = 1'b1;
      c.idex_bubble = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side hazard inputs and pipeline-control outputs of the hazard controller.
interface hazard_stall_ctrl_if #(
   parameter int unsigned REG_W = 5
);
   logic [REG_W-1:0] ID_rs1_i;
   logic [REG_W-1:0] ID_rs2_i;
   logic             IDEX_MemRead_i;
   logic [REG_W-1:0] IDEX_rd_i;
   logic             Branch_taken_i;
   logic             imem_ready_i;
   logic             dmem_req_i;
   logic             dmem_ready_i;
   logic             PC_write_o;
   logic             IFID_Stall_o;
   logic             IFID_Flush_o;
   logic             IDEX_Bubble_o;
   logic             Freeze_o;
   logic             imem_abort_o;

   modport master (
      output ID_rs1_i, ID_rs2_i, IDEX_MemRead_i, IDEX_rd_i, Branch_taken_i,
             imem_ready_i, dmem_req_i, dmem_ready_i,
      input  PC_write_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o, imem_abort_o
   );

   modport slave (
      input  ID_rs1_i, ID_rs2_i, IDEX_MemRead_i, IDEX_rd_i, Branch_taken_i,
             imem_ready_i, dmem_req_i, dmem_ready_i,
      output PC_write_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o, imem_abort_o
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// IF/ID and PC sequencing from load-use, taken-branch and memory-wait hazards,
// with saturating stall/flush statistics.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   hazard_stall_ctrl_if.slave hz,
   output logic [CNT_W-1:0]   Stall_cnt_o,
   output logic [CNT_W-1:0]   Flush_cnt_o
);

   localparam logic [REG_W-1:0] X0 = '0;

   logic [1:0] state_q, state_d;
   logic       lu, dmiss;
   hz_ctrl_t   run_ctrl, ctrl;
   logic [1:0] run_next;
   logic       run_flush, flush_inc, stall_inc;

   assign lu = hz.IDEX_MemRead_i && (hz.IDEX_rd_i != X0) &&
               ((hz.IDEX_rd_i == hz.ID_rs1_i) || (hz.IDEX_rd_i == hz.ID_rs2_i));
   assign dmiss = hz.dmem_req_i && !hz.dmem_ready_i;

   // Normal-issue decision, also used on the cycle a data wait releases.
   always_comb begin
      run_ctrl  = '0;
      run_next  = HZ_RUN;
      run_flush = 1'b0;
      if (dmiss) begin
         run_ctrl.freeze     = 1'b1;
         run_ctrl.ifid_stall = 1'b1;
         run_next            = HZ_DWAIT;
      end else if (lu) begin
         // Branch operands depend on the load, so a same-cycle branch is not honoured.
         run_ctrl.ifid_stall  = 1'b1;
         run_ctrl.idex_bubble = 1'b1;
      end else if (hz.Branch_taken_i) begin
         run_ctrl.pc_write   = 1'b1;
         run_ctrl.ifid_flush = 1'b1;
         run_flush           = 1'b1;
      end else if (!hz.imem_ready_i) begin
         run_ctrl.ifid_flush = 1'b1;
         run_next            = HZ_IWAIT;
      end else begin
         run_ctrl.pc_write = 1'b1;
      end
   end

   always_comb begin
      ctrl      = run_ctrl;
      state_d   = run_next;
      flush_inc = run_flush;
      case (state_q)
         HZ_DWAIT: begin
            if (!hz.dmem_ready_i) begin
               ctrl            = '0;
               ctrl.freeze     = 1'b1;
               ctrl.ifid_stall = 1'b1;
               state_d         = HZ_DWAIT;
               flush_inc       = 1'b0;
            end
         end
         HZ_IWAIT: begin
            // IF/ID already holds the NOP here, so load-use cannot match.
            if (!dmiss) begin
               ctrl      = '0;
               flush_inc = 1'b0;
               state_d   = HZ_RUN;
               if (hz.Branch_taken_i) begin
                  ctrl.pc_write   = 1'b1;
                  ctrl.imem_abort = 1'b1;
                  ctrl.ifid_flush = 1'b1;
                  flush_inc       = 1'b1;
               end else if (hz.imem_ready_i) begin
                  ctrl.pc_write = 1'b1;
               end else begin
                  ctrl.ifid_flush = 1'b1;
                  state_d         = HZ_IWAIT;
               end
            end
         end
         default: ;
      endcase
      if (rst_i) begin
         ctrl      = ctrl_reset();
         flush_inc = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= HZ_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign stall_inc = !ctrl.pc_write && !rst_i;

   assign hz.PC_write_o    = ctrl.pc_write;
   assign hz.IFID_Stall_o  = ctrl.ifid_stall;
   assign hz.IFID_Flush_o  = ctrl.ifid_flush;
   assign hz.IDEX_Bubble_o = ctrl.idex_bubble;
   assign hz.Freeze_o      = ctrl.freeze;
   assign hz.imem_abort_o  = ctrl.imem_abort;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (stall_inc),
      .cnt_o (Stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush_inc),
      .cnt_o (Flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected control vectors are queued as each
// cycle is driven and popped when the outputs are sampled mid-cycle.
module tb_hazard_stall_ctrl;

   localparam int unsigned RW = 5;
   localparam int unsigned CW = 8;

   typedef struct packed {
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic [RW-1:0] rd;
      logic          mr;
      logic          br;
      logic          ir;
      logic          dq;
      logic          dr;
   } stim_t;

   typedef struct packed {
      logic pc;
      logic stall;
      logic flush;
      logic bubble;
      logic freeze;
      logic abort;
   } exp_t;

   localparam exp_t E_RUN = '{pc: 1'b1, default: 1'b0};
   localparam exp_t E_LU  = '{stall: 1'b1, bubble: 1'b1, default: 1'b0};
   localparam exp_t E_FRZ = '{stall: 1'b1, freeze: 1'b1, default: 1'b0};
   localparam exp_t E_BR  = '{pc: 1'b1, flush: 1'b1, default: 1'b0};
   localparam exp_t E_IW  = '{flush: 1'b1, default: 1'b0};
   localparam exp_t E_ABT = '{pc: 1'b1, flush: 1'b1, abort: 1'b1, default: 1'b0};
   localparam exp_t E_RST = '{flush: 1'b1, bubble: 1'b1, default: 1'b0};

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   hazard_stall_ctrl_if #(.REG_W(RW)) hz ();

   hazard_stall_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .hz          (hz),
      .Stall_cnt_o (stall_cnt),
      .Flush_cnt_o (flush_cnt)
   );

   function automatic stim_t st(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                input logic [RW-1:0] rd, input logic mr, input logic br,
                                input logic ir, input logic dq, input logic dr);
      stim_t s;
      s = '{rs1: rs1, rs2: rs2, rd: rd, mr: mr, br: br, ir: ir, dq: dq, dr: dr};
      return s;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o = '{pc: hz.PC_write_o, stall: hz.IFID_Stall_o, flush: hz.IFID_Flush_o,
            bubble: hz.IDEX_Bubble_o, freeze: hz.Freeze_o, abort: hz.imem_abort_o};
      return o;
   endfunction

   task automatic drive(input stim_t s, input exp_t e);
      hz.ID_rs1_i       = s.rs1;
      hz.ID_rs2_i       = s.rs2;
      hz.IDEX_rd_i      = s.rd;
      hz.IDEX_MemRead_i = s.mr;
      hz.Branch_taken_i = s.br;
      hz.imem_ready_i   = s.ir;
      hz.dmem_req_i     = s.dq;
      hz.dmem_ready_i   = s.dr;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      exp_t got, e;
      drive(st(0, 0, 0, 0, 1, 0, 1, 0), E_RST);
      #2;
      got = observe();
      e   = sb_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL reset_outputs got %b exp %b", got, e);
      end
      checks++;
      if (stall_cnt !== 0 || flush_cnt !== 0) begin
         errors++;
         $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic test_load_use();
      stim_t s[5];
      exp_t  x[5];
      exp_t  got, e;
      do_reset();
      s = '{st(5, 0, 5, 1, 0, 1, 0, 0), st(5, 0, 5, 0, 0, 1, 0, 0), st(0, 0, 0, 1, 0, 1, 0, 0),
            st(1, 7, 7, 1, 0, 1, 0, 0), st(7, 0, 7, 0, 0, 1, 0, 0)};
      x = '{E_LU, E_RUN, E_RUN, E_LU, E_RUN};
      for (int i = 0; i < 5; i++) begin
         drive(s[i], x[i]);
         #4;
         got = observe();
         e   = sb_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL load_use cyc%0d got %b exp %b", i, got, e);
         end
         @(posedge clk_i);
         #1;
      end
      checks++;
      if (stall_cnt !== 2 || flush_cnt !== 0) begin
         errors++;
         $display("FAIL load_use_cnt got %0d/%0d exp 2/0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_branch();
      stim_t s[4];
      exp_t  x[4];
      exp_t  got, e;
      do_reset();
      s = '{st(0, 0, 0, 0, 1, 0, 0, 0), st(0, 0, 0, 0, 0, 1, 0, 0), st(0, 4, 4, 1, 1, 1, 0, 0),
            st(0, 0, 0, 0, 0, 1, 0, 0)};
      x = '{E_BR, E_RUN, E_LU, E_RUN};
      for (int i = 0; i < 4; i++) begin
         drive(s[i], x[i]);
         #4;
         got = observe();
         e   = sb_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL branch cyc%0d got %b exp %b", i, got, e);
         end
         @(posedge clk_i);
         #1;
      end
      checks++;
      if (stall_cnt !== 1 || flush_cnt !== 1) begin
         errors++;
         $display("FAIL branch_cnt got %0d/%0d exp 1/1", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_dwait();
      stim_t s[5];
      exp_t  x[5];
      exp_t  got, e;
      do_reset();
      s = '{st(3, 0, 3, 1, 1, 1, 1, 0), st(0, 0, 0, 0, 1, 1, 1, 0), st(0, 0, 0, 0, 1, 1, 1, 0),
            st(0, 0, 0, 0, 1, 1, 1, 1), st(0, 0, 0, 0, 0, 1, 0, 0)};
      x = '{E_FRZ, E_FRZ, E_FRZ, E_BR, E_RUN};
      for (int i = 0; i < 5; i++) begin
         drive(s[i], x[i]);
         #4;
         got = observe();
         e   = sb_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL dwait cyc%0d got %b exp %b", i, got, e);
         end
         @(posedge clk_i);
         #1;
      end
      checks++;
      if (stall_cnt !== 3 || flush_cnt !== 1) begin
         errors++;
         $display("FAIL dwait_cnt got %0d/%0d exp 3/1", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_iwait();
      stim_t s[10];
      exp_t  x[10];
      exp_t  got, e;
      do_reset();
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 1, 0, 0, 0),
            st(0, 0, 0, 0, 0, 1, 0, 0), st(0, 0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 1, 0, 0),
            st(0, 0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 1, 1),
            st(0, 0, 0, 0, 0, 1, 0, 0)};
      x = '{E_IW, E_IW, E_ABT, E_RUN, E_IW, E_RUN, E_IW, E_FRZ, E_RUN, E_RUN};
      for (int i = 0; i < 10; i++) begin
         drive(s[i], x[i]);
         #4;
         got = observe();
         e   = sb_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL iwait cyc%0d got %b exp %b", i, got, e);
         end
         @(posedge clk_i);
         #1;
      end
      checks++;
      if (stall_cnt !== 5 || flush_cnt !== 1) begin
         errors++;
         $display("FAIL iwait_cnt got %0d/%0d exp 5/1", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_reset_mid_dwait();
      exp_t got, e;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(st(0, 0, 0, 0, 1, 1, 1, 0), E_FRZ);
         #4;
         got = observe();
         e   = sb_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mid_dwait cyc%0d got %b exp %b", i, got, e);
         end
         @(posedge clk_i);
         #1;
      end
      drive(st(0, 0, 0, 0, 1, 1, 1, 0), E_RST);
      #2;
      rst_i = 1'b1;
      #1;
      got = observe();
      e   = sb_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL async_reset_outputs got %b exp %b", got, e);
      end
      checks++;
      if (stall_cnt !== 0 || flush_cnt !== 0) begin
         errors++;
         $display("FAIL async_reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      // dmem_ready stays low: a controller stuck in DWAIT would still freeze here.
      drive(st(0, 0, 0, 0, 0, 1, 0, 0), E_RUN);
      #4;
      got = observe();
      e   = sb_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL post_reset_run got %b exp %b", got, e);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_back_to_back();
      exp_t got, e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(st(0, 0, 0, 0, 1, 1, 0, 0), E_BR);
         else       drive(st(0, 0, 0, 0, 0, 1, 0, 0), E_RUN);
         #4;
         got = observe();
         e   = sb_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL back_to_back cyc%0d got %b exp %b", i, got, e);
         end
         @(posedge clk_i);
         #1;
      end
      checks++;
      if (stall_cnt !== 0 || flush_cnt !== 3) begin
         errors++;
         $display("FAIL back_to_back_cnt got %0d/%0d exp 0/3", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_saturation();
      exp_t got, e;
      do_reset();
      for (int i = 0; i < 260; i++) begin
         drive(st(5, 0, 5, 1, 0, 1, 0, 0), E_LU);
         #4;
         got = observe();
         e   = sb_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL saturation cyc%0d got %b exp %b", i, got, e);
         end
         @(posedge clk_i);
         #1;
      end
      checks++;
      if (stall_cnt !== 8'hFF || flush_cnt !== 0) begin
         errors++;
         $display("FAIL saturation_cnt got %0d/%0d exp 255/0", stall_cnt, flush_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_dwait();
      test_iwait();
      test_reset_mid_dwait();
      test_back_to_back();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
